// File: rtl/mbldcm_pkg.sv
// mbldcm_pkg: shared addresses, command/error codes, status bits and FSM encoding for the AVMM master.
package mbldcm_pkg;
  localparam logic [1:0] ADDR_FREQ = 2'd0;
  localparam logic [1:0] ADDR_PHASE = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;
  localparam logic [1:0] CMD_RUN = 2'd0;
  localparam logic [1:0] CMD_STOP = 2'd1;
  localparam logic [1:0] CMD_SETFREQ = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_RESP = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_DATA = 2'd3;
  localparam int STAT_STOP_BIT = 0;
  localparam int STAT_FREQ_BIT = 1;
  typedef enum logic [2:0] {IDLE, WR_FREQ, RD_FREQ, WR_CTRL, GAP, RD_STAT, FIN} state_t;
  // STOP waits for the stop flag, every other command waits for the frequency to be reflected
  function automatic logic [31:0] stat_mask(input logic [1:0] cmd);
    return 32'd1 << (cmd == CMD_STOP ? STAT_STOP_BIT : STAT_FREQ_BIT);
  endfunction
endpackage

// File: rtl/mbldcm_avmm_xfer.sv
// mbldcm_avmm_xfer: Avalon-MM single-transfer handshake; request is held by the caller until done.
module mbldcm_avmm_xfer (
  input  logic        req,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        rnw,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  output logic [1:0]  oAddr,
  output logic        oRead,
  output logic        oWrite,
  output logic [31:0] oWdata,
  input  logic [31:0] iRdata,
  input  logic [1:0]  iResp,
  input  logic        iWaitrequest
);
  assign oRead = req & rnw;
  assign oWrite = req & ~rnw;
  assign oAddr = addr;
  assign oWdata = wdata;
  assign done = req & ~iWaitrequest;
  assign rdata = iRdata;
  assign resp = iResp;
endmodule

// File: rtl/mbldcm_avmm_master.sv
// mbldcm_avmm_master: sequences RUN/STOP/SETFREQ commands over Avalon-MM and polls Status.
// Define MBLDCM_AVMM_MASTER_READBACK_EN to read FreqTarget back after writing it.
module mbldcm_avmm_master
  import mbldcm_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 1024
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [1:0]  iCmd,
  input  logic [31:0] iFreq,
  output logic        oBusy,
  output logic        oDone,
  output logic [1:0]  oErrCode,
  output logic [1:0]  oAddr,
  output logic        oRead,
  output logic        oWrite,
  output logic [31:0] oWdata,
  input  logic [31:0] iRdata,
  input  logic [1:0]  iResp,
  input  logic        iWaitrequest
);
  state_t state;
  logic req, rnw, xfer_done, resp_bad, stat_hit, poll_last;
  logic [1:0] addr, cmd, xfer_resp;
  logic [31:0] wdata, xfer_rdata;
  logic [15:0] poll_cnt, gap_cnt;
  assign resp_bad = xfer_resp != 2'd0;
  assign stat_hit = |(xfer_rdata & stat_mask(cmd));
  assign poll_last = poll_cnt + 16'd1 == 16'(POLL_MAX);
  mbldcm_avmm_xfer u_xfer (
    .req(req), .addr(addr), .wdata(wdata), .rnw(rnw),
    .done(xfer_done), .rdata(xfer_rdata), .resp(xfer_resp),
    .oAddr(oAddr), .oRead(oRead), .oWrite(oWrite), .oWdata(oWdata),
    .iRdata(iRdata), .iResp(iResp), .iWaitrequest(iWaitrequest)
  );
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state <= IDLE;
      req <= 1'b0;
      rnw <= 1'b0;
      addr <= '0;
      wdata <= '0;
      cmd <= '0;
      poll_cnt <= '0;
      gap_cnt <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oErrCode <= ERR_OK;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          oBusy <= 1'b1;
          oErrCode <= ERR_OK;
          cmd <= iCmd;
          poll_cnt <= '0;
          if (iCmd == CMD_RSVD) begin state <= FIN; oDone <= 1'b1; oErrCode <= ERR_DATA; end
          else if (iCmd == CMD_STOP) begin state <= WR_CTRL; req <= 1'b1; rnw <= 1'b0; addr <= ADDR_CTRL; wdata <= '0; end
          else begin state <= WR_FREQ; req <= 1'b1; rnw <= 1'b0; addr <= ADDR_FREQ; wdata <= iFreq; end
        end
        WR_FREQ: if (xfer_done) begin
          if (resp_bad) begin state <= FIN; req <= 1'b0; oDone <= 1'b1; oErrCode <= ERR_RESP; end
`ifdef MBLDCM_AVMM_MASTER_READBACK_EN
          else begin state <= RD_FREQ; rnw <= 1'b1; end
        end
        RD_FREQ: if (xfer_done) begin
          if (resp_bad) begin state <= FIN; req <= 1'b0; oDone <= 1'b1; oErrCode <= ERR_RESP; end
          else if (xfer_rdata != wdata) begin state <= FIN; req <= 1'b0; oDone <= 1'b1; oErrCode <= ERR_DATA; end
`endif
          else if (cmd == CMD_RUN) begin state <= WR_CTRL; rnw <= 1'b0; addr <= ADDR_CTRL; wdata <= 32'd1; end
          else begin state <= RD_STAT; rnw <= 1'b1; addr <= ADDR_STAT; end
        end
        WR_CTRL: if (xfer_done) begin
          if (resp_bad) begin state <= FIN; req <= 1'b0; oDone <= 1'b1; oErrCode <= ERR_RESP; end
          else begin state <= RD_STAT; rnw <= 1'b1; addr <= ADDR_STAT; wdata <= '0; end
        end
        RD_STAT: if (xfer_done) begin
          poll_cnt <= poll_cnt + 16'd1;
          if (resp_bad) begin state <= FIN; req <= 1'b0; oDone <= 1'b1; oErrCode <= ERR_RESP; end
          else if (stat_hit) begin state <= FIN; req <= 1'b0; oDone <= 1'b1; end
          else if (poll_last) begin state <= FIN; req <= 1'b0; oDone <= 1'b1; oErrCode <= ERR_TIMEOUT; end
          else if (POLL_GAP != 0) begin state <= GAP; req <= 1'b0; gap_cnt <= '0; end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_cnt == 16'(POLL_GAP - 1)) begin state <= RD_STAT; req <= 1'b1; end
        end
        FIN: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbldcm_avmm_master.sv
// tb_mbldcm_avmm_master: directed and randomized command runs against a behavioural Avalon-MM slave and model.
module tb_mbldcm_avmm_master;
  localparam int PG = 3;
  localparam int PM = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [31:0] freq = 32'd0;
  logic busy, done, rd, wr, waitreq = 1'b0;
  logic [1:0] err, addr, resp = 2'd0;
  logic [31:0] wdata, rdata = 32'd0;
  int checks = 0, failures = 0, cyc = 0;
  int cfg_wait = 0, hit_at = 0, err_idx = -1, wait_left = 0, n_done = 0, n_stat = 0, start_c = 0;
  bit hold = 1'b0, fresh = 1'b1, rb_bad = 1'b0;
  logic [31:0] rb_val = 32'd0, rb_bad_val = 32'd0;
  logic [1:0] cur_cmd = 2'd0;
  logic [35:0] snap = '0;
  logic [34:0] log_q[$], exp_q[$];
  int st_q[$], en_q[$];

  always #5 clk = ~clk;

  mbldcm_avmm_master #(.POLL_GAP(PG), .POLL_MAX(PM)) dut (
    .iClock(clk), .iReset(rst), .iStart(start), .iCmd(cmd), .iFreq(freq),
    .oBusy(busy), .oDone(done), .oErrCode(err),
    .oAddr(addr), .oRead(rd), .oWrite(wr), .oWdata(wdata),
    .iRdata(rdata), .iResp(resp), .iWaitrequest(waitreq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_val(input int read_no);
    logic [31:0] aw;
    aw = cur_cmd == 2'd1 ? 32'd1 : 32'd2;
    return ($urandom & ~32'd3) | ((hit_at > 0 && read_no >= hit_at) ? aw : 32'd0)
           | ($urandom_range(0, 1) == 1 ? (aw ^ 32'd3) : 32'd0);
  endfunction

  // Slave: inserts cfg_wait wait states per transfer, logs each completed transfer with its cycle span
  always @(negedge clk) begin
    cyc++;
    chk("rw_exclusive", {62'd0, rd, wr} == 64'd3, 64'd0);
    if (rd | wr) begin
      if (hold) chk("hold_stable", {rd, wr, addr, wdata}, snap);
      if (fresh) begin start_c = cyc; fresh = 1'b0; end
      if (wait_left > 0) begin
        waitreq = 1'b1; resp = 2'd0; wait_left--; hold = 1'b1; snap = {rd, wr, addr, wdata};
      end else begin
        waitreq = 1'b0; hold = 1'b0; fresh = 1'b1; wait_left = cfg_wait;
        resp = n_done == err_idx ? 2'd2 : 2'd0;
        rdata = addr == 2'd0 ? rb_val : addr == 2'd3 ? stat_val(n_stat + 1) : $urandom;
        if (rd && addr == 2'd3) n_stat++;
        log_q.push_back({wr, addr, wr ? wdata : 32'd0});
        st_q.push_back(start_c);
        en_q.push_back(cyc);
        n_done++;
      end
    end else begin
      waitreq = 1'b0; hold = 1'b0; fresh = 1'b1; wait_left = cfg_wait; resp = 2'd0;
    end
  end

  // Expected transfer list and error code derived from the command rules
  task automatic model(input logic [1:0] c, input logic [31:0] f, output logic [1:0] e);
    logic [34:0] full[$];
    int stop, n;
    logic [1:0] se;
    exp_q.delete();
    e = 2'd3;
    stop = -1;
    se = 2'd0;
    if (c != 2'd3) begin
      if (c != 2'd1) begin
        full.push_back({1'b1, 2'd0, f});
`ifdef MBLDCM_AVMM_MASTER_READBACK_EN
        full.push_back({1'b0, 2'd0, 32'd0});
        if (rb_val != f) begin stop = 1; se = 2'd3; end
`endif
      end
      if (stop < 0) begin
        if (c != 2'd2) full.push_back({1'b1, 2'd2, c == 2'd0 ? 32'd1 : 32'd0});
        n = (hit_at >= 1 && hit_at <= PM) ? hit_at : PM;
        repeat (n) full.push_back({1'b0, 2'd3, 32'd0});
        se = (hit_at >= 1 && hit_at <= PM) ? 2'd0 : 2'd2;
        stop = full.size() - 1;
      end
      if (err_idx >= 0 && err_idx <= stop) begin stop = err_idx; se = 2'd1; end
      for (int i = 0; i <= stop; i++) exp_q.push_back(full[i]);
      e = se;
    end
  endtask

  task automatic run(input logic [1:0] c, input logic [31:0] f, input string tag);
    logic [1:0] e;
    int k;
    bit got;
    rb_val = rb_bad ? rb_bad_val : f;
    model(c, f, e);
    log_q.delete(); st_q.delete(); en_q.delete();
    n_done = 0; n_stat = 0; cur_cmd = c;
    @(negedge clk);
    start = 1'b1; cmd = c; freq = f;
    @(negedge clk);
    start = 1'b0;
    if (c != 2'd3) begin
      chk({tag, "_busy_after_start"}, busy, 1);
      chk({tag, "_err_cleared"}, err, 0);
    end
    got = 1'b0;
    k = 0;
    while (!got && k < 2000) begin
      if (done) got = 1'b1;
      else begin
        start = k == 0 && c != 2'd3;
        cmd = start ? 2'd3 : c;
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_err"}, err, e);
    chk({tag, "_busy_in_fin"}, busy, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_err_held"}, err, e);
    chk({tag, "_n_xfers"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), log_q[i], exp_q[i]);
    for (int i = 1; i < log_q.size(); i++)
      if (log_q[i][34:32] == 3'b011 && log_q[i-1][34:32] == 3'b011)
        chk($sformatf("%s_gap%0d", tag, i), st_q[i] - en_q[i-1] - 1, PG);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk({tag, "_outs_zero"}, {rd, wr, addr, wdata, busy, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic begin_run(input logic [1:0] c, input logic [31:0] f);
    log_q.delete(); st_q.delete(); en_q.delete();
    n_done = 0; n_stat = 0; cur_cmd = c;
    @(negedge clk);
    start = 1'b1; cmd = c; freq = f;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k, r;
    logic [1:0] c;
    #1 chk("reset_outs", {rd, wr, addr, wdata, busy, done, err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {rd, wr, busy, done, err}, 0);

    cfg_wait = 0; hit_at = 3; err_idx = -1; rb_bad = 1'b0;
    run(2'd0, 32'h0000_1F40, "run_basic");

    cfg_wait = 3; hit_at = 2;
    run(2'd1, $urandom, "stop_wait");

    cfg_wait = 0; hit_at = 0;
    run(2'd2, $urandom, "setfreq_timeout");

    hit_at = 1; err_idx = 0;
    run(2'd0, $urandom, "resp_err");
    err_idx = -1;

`ifdef MBLDCM_AVMM_MASTER_READBACK_EN
    rb_bad = 1'b1; rb_bad_val = 32'd0;
    run(2'd2, 32'h0000_0010, "readback_bad");
    rb_bad = 1'b0;
`endif

    run(2'd3, $urandom, "bad_cmd");

    hit_at = 0;
    begin_run(2'd0, $urandom | 32'd1);
    k = 0;
    while (log_q.size() < 3 && k < 100) begin @(negedge clk); k++; end
    chk("gap_reached_first_poll", log_q.size(), 3);
    chk("gap_busy", busy, 1);
    reset_pulse("rst_in_gap");

    cfg_wait = 1000;
    begin_run(2'd0, $urandom | 32'h8000_0000);
    repeat (2) @(negedge clk);
    chk("wait_write_active", wr, 1);
    reset_pulse("rst_in_wait");
    cfg_wait = 0;

    hit_at = 2;
    run(2'd0, $urandom, "after_reset");

    for (int i = 0; i < 12; i++) begin
      r = int'($urandom_range(0, 9));
      c = r == 9 ? 2'd3 : 2'(r % 3);
      cfg_wait = int'($urandom_range(0, 2));
      hit_at = int'($urandom_range(0, 5));
      err_idx = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 3)) : -1;
      rb_bad = $urandom_range(0, 4) == 0;
      rb_bad_val = $urandom;
      run(c, $urandom, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
